mem_loader_ctrl: RTL and testbench
==================================

// Module: mem_loader_ctrl
// PURPOSE
//   Sequences the loading of program/data words into ram_memory from a byte stream (debug UART RX path).
//   Assembles 4 bytes into one 32-bit word and drives the RAM write port (data, write_enable, write_data_next strobe).
//   Tracks the fill address and ends the session on an end-of-program word or on RAM overflow.
//   Sits between the UART receiver / debug unit and ram_memory.
// PARAMETERS
//   NB_DATA      32            word width written to RAM
//   NB_BYTE      8             input byte width
//   NB_ADDRESS   8             RAM address width
//   RAM_DEPTH    256           RAM depth in words
//   WRITE_WAIT   6             idle cycles after each write_data_next pulse (RAM commit time)
//   END_WORD     32'hFFFFFFFF  terminating word; it is stored, then the session ends
// PORTS
//   i_clock                in   1           clock, all logic on rising edge
//   i_reset                in   1           synchronous, active-low reset
//   i_start                in   1           one-cycle pulse: open a load session (ignored while o_busy)
//   i_rx_data              in   NB_BYTE     received byte
//   i_rx_valid             in   1           i_rx_data valid; byte taken when i_rx_valid & o_rx_ready
//   o_rx_ready             out  1           controller accepts a byte this cycle
//   o_ram_write_data       out  NB_DATA     assembled word to RAM
//   o_ram_write_enable     out  1           high for the whole session (RECV/WRITE/WAIT)
//   o_ram_write_data_next  out  1           one-cycle strobe: RAM stores o_ram_write_data
//   o_ram_address          out  NB_ADDRESS  address of the word being filled
//   o_words_loaded         out  NB_ADDRESS+1  words written this session, END_WORD included
//   o_busy                 out  1           session in progress
//   o_done                 out  1           one-cycle pulse at session end
//   o_overflow             out  1           sticky: RAM filled without END_WORD; cleared by next i_start
// BEHAVIOUR
//   Reset (i_reset==0 at posedge): state IDLE; all outputs 0; byte count and partial word discarded.
//   FSM: IDLE -> RECV on i_start (clears address, words_loaded, overflow).
//     RECV: o_rx_ready=1; each handshake shifts in a byte, first byte = MSB (big-endian).
//           After 4th byte -> WRITE next cycle; the word is stable on o_ram_write_data from that cycle.
//     WRITE: o_ram_write_data_next=1 for exactly 1 cycle; words_loaded += 1 -> WAIT.
//     WAIT: WRITE_WAIT cycles, o_rx_ready=0. Exit:
//           word==END_WORD                   -> DONE (address not incremented)
//           address==RAM_DEPTH-1 (last slot) -> o_overflow=1, DONE
//           else address += 1                -> RECV
//     DONE: o_done=1 one cycle, write_enable drops -> IDLE.
//   Latency: 4th byte accepted at cycle N -> strobe at N+1 -> ready again at N+2+WRITE_WAIT.
//   o_rx_ready low in IDLE/WRITE/WAIT/DONE; bytes offered there are not consumed.
//   i_start while busy: ignored. Reset mid-session: abort, no further strobe, partial word lost.
//   Address never wraps: overflow stops the session after writing slot RAM_DEPTH-1.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined: extra port o_checksum out NB_BYTE = XOR of every accepted byte this
//     session; cleared on i_start and reset; valid when o_done pulses and held until next i_start.
//   Not defined: no o_checksum port, no checksum logic.
// STRUCTURE
//   Package mem_loader_pkg: state enum (IDLE, RECV, WRITE, WAIT, DONE), END_WORD default,
//     BYTES_PER_WORD = NB_DATA/NB_BYTE.
//   Sub-module byte_assembler: shift register + 2-bit byte counter; outputs word and word_valid pulse;
//     clear input driven from the FSM.
// TESTING (bench instantiates mem_loader_ctrl + ram_memory)
//   1 start, bytes AA BB CC 55 -> one strobe, RAM[0]=32'hAABBCC55, address 0->1, ready low 1+WRITE_WAIT cycles.
//   2 words 11223344, 89ABCDEF, then FF FF FF FF -> RAM[0..2] written, o_done pulse, o_words_loaded=3, overflow=0.
//   3 i_rx_valid toggling every other cycle + i_start during WAIT -> same RAM content, start ignored.
//   4 256 non-end words -> RAM[255] written, o_overflow=1, o_done pulse, o_ram_address=255, no wrap.
//   5 reset low after 2 bytes, then new session with 00AA00BB -> RAM[0]=32'h00AA00BB, no stray strobe.
//   6 LOADER_CHECKSUM_EN: bytes 01 02 04 08 + FF FF FF FF -> o_checksum=8'h0F at o_done.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared types and default parameters for the memory loader controller.
//   state_t        : loader session states
//   *_DEF          : default widths, depth, commit wait and terminating word
//   BYTES_PER_WORD : bytes assembled into one RAM word
package mem_loader_pkg;

  localparam int unsigned NB_DATA_DEF    = 32;
  localparam int unsigned NB_BYTE_DEF    = 8;
  localparam int unsigned NB_ADDRESS_DEF = 8;
  localparam int unsigned RAM_DEPTH_DEF  = 256;
  localparam int unsigned WRITE_WAIT_DEF = 6;
  localparam logic [31:0] END_WORD_DEF   = 32'hFFFF_FFFF;
  localparam int unsigned BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in the MSBs.
// Ports:
//   i_clock, i_reset (sync, active-low)
//   i_clear        : discard partial word and byte count
//   i_take         : accept i_byte this cycle
//   o_word         : shift register contents (complete after the last byte)
//   o_word_valid_c : combinational, high while the last byte of a word is taken
module byte_assembler
  import mem_loader_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_BYTE = NB_BYTE_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_take,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid_c
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0] byte_cnt;

  // Combinational so the controller can leave RECV on the same edge that stores the last byte.
  assign o_word_valid_c = i_take & (byte_cnt == LAST_BYTE);

  // Shift register and byte counter; counter wraps to 0 after the last byte.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_word   <= '0;
      byte_cnt <= '0;
    end else if (i_clear) begin
      o_word   <= '0;
      byte_cnt <= '0;
    end else if (i_take) begin
      o_word   <= {o_word[NB_DATA-NB_BYTE-1:0], i_byte};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/mem_loader_ctrl.sv
// Loads words into ram_memory from a byte stream (debug UART RX path).
// Four bytes are assembled big-endian into a word, written with a one-cycle
// strobe, then the RAM is given WRITE_WAIT cycles to commit. The session ends
// on END_WORD (stored) or after filling the last RAM slot (o_overflow).
// Ports:
//   i_clock, i_reset (sync, active-low), i_start (session open pulse)
//   i_rx_data / i_rx_valid / o_rx_ready : byte handshake
//   o_ram_write_data / o_ram_write_enable / o_ram_write_data_next / o_ram_address : RAM write port
//   o_words_loaded, o_busy, o_done, o_overflow : session status
// Optional: define LOADER_CHECKSUM_EN to add o_checksum (XOR of accepted bytes).
module mem_loader_ctrl
  import mem_loader_pkg::*;
#(
  parameter int unsigned         NB_DATA    = NB_DATA_DEF,
  parameter int unsigned         NB_BYTE    = NB_BYTE_DEF,
  parameter int unsigned         NB_ADDRESS = NB_ADDRESS_DEF,
  parameter int unsigned         RAM_DEPTH  = RAM_DEPTH_DEF,
  parameter int unsigned         WRITE_WAIT = WRITE_WAIT_DEF,
  parameter logic [NB_DATA-1:0]  END_WORD   = NB_DATA'(END_WORD_DEF)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic [NB_DATA-1:0]    o_ram_write_data,
  output logic                  o_ram_write_enable,
  output logic                  o_ram_write_data_next,
  output logic [NB_ADDRESS-1:0] o_ram_address,
  output logic [NB_ADDRESS:0]   o_words_loaded,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [NB_BYTE-1:0]    o_checksum
`endif
);

  localparam int unsigned NB_WAIT  = $clog2(WRITE_WAIT + 1);
  localparam int unsigned NB_COUNT = NB_ADDRESS + 1;

  state_t             state;
  logic [NB_WAIT-1:0] wait_cnt;
  logic               take_c;
  logic               start_c;
  logic               word_valid_c;

  assign take_c  = i_rx_valid & o_rx_ready;
  assign start_c = (state == IDLE) & i_start;

  byte_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_byte_assembler (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_clear        (start_c),
    .i_take         (take_c),
    .i_byte         (i_rx_data),
    .o_word         (o_ram_write_data),
    .o_word_valid_c (word_valid_c)
  );

  // Session FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state                 <= IDLE;
      wait_cnt              <= '0;
      o_rx_ready            <= 1'b0;
      o_ram_write_enable    <= 1'b0;
      o_ram_write_data_next <= 1'b0;
      o_ram_address         <= '0;
      o_words_loaded        <= '0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      o_overflow            <= 1'b0;
    end else begin
      o_ram_write_data_next <= 1'b0;
      o_done                <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state              <= RECV;
            o_rx_ready         <= 1'b1;
            o_ram_write_enable <= 1'b1;
            o_busy             <= 1'b1;
            o_ram_address      <= '0;
            o_words_loaded     <= '0;
            o_overflow         <= 1'b0;
          end
        end
        RECV: begin
          if (word_valid_c) begin
            state                 <= WRITE;
            o_rx_ready            <= 1'b0;
            o_ram_write_data_next <= 1'b1;
          end
        end
        WRITE: begin
          state          <= WAIT;
          wait_cnt       <= '0;
          o_words_loaded <= o_words_loaded + NB_COUNT'(1);
        end
        WAIT: begin
          if (wait_cnt == NB_WAIT'(WRITE_WAIT - 1)) begin
            // END_WORD takes priority over overflow when both hit on the last slot.
            if (o_ram_write_data == END_WORD) begin
              state              <= DONE;
              o_done             <= 1'b1;
              o_ram_write_enable <= 1'b0;
            end else if (o_ram_address == NB_ADDRESS'(RAM_DEPTH - 1)) begin
              state              <= DONE;
              o_done             <= 1'b1;
              o_ram_write_enable <= 1'b0;
              o_overflow         <= 1'b1;
            end else begin
              state         <= RECV;
              o_rx_ready    <= 1'b1;
              o_ram_address <= o_ram_address + NB_ADDRESS'(1);
            end
          end else begin
            wait_cnt <= wait_cnt + NB_WAIT'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state              <= IDLE;
          o_rx_ready         <= 1'b0;
          o_ram_write_enable <= 1'b0;
          o_busy             <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // XOR of every accepted byte; holds after the session until the next start.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_checksum <= '0;
    end else if (start_c) begin
      o_checksum <= '0;
    end else if (take_c) begin
      o_checksum <= o_checksum ^ i_rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_loader_ctrl.sv
// Bench for mem_loader_ctrl: timestamp-based session model plus RAM image compare.
module tb_mem_loader_ctrl;

  localparam int WW = 6;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic [31:0] o_ram_write_data;
  logic        o_ram_write_enable;
  logic        o_ram_write_data_next;
  logic [7:0]  o_ram_address;
  logic [8:0]  o_words_loaded;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  o_checksum;
`endif

  always #5 clk = ~clk;

  mem_loader_ctrl dut (
    .i_clock               (clk),
    .i_reset               (i_reset),
    .i_start               (i_start),
    .i_rx_data             (i_rx_data),
    .i_rx_valid            (i_rx_valid),
    .o_rx_ready            (o_rx_ready),
    .o_ram_write_data      (o_ram_write_data),
    .o_ram_write_enable    (o_ram_write_enable),
    .o_ram_write_data_next (o_ram_write_data_next),
    .o_ram_address         (o_ram_address),
    .o_words_loaded        (o_words_loaded),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_overflow            (o_overflow)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_checksum            (o_checksum)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event timestamps, in cycles) ----------------
  bit          mon_en = 1'b0;
  int          cyc = 0;
  bit          act = 1'b0;
  int          rdy_from = 0;
  int          strobe_at = -1;
  int          decide_at = -1;
  int          done_at = -1;
  int          m_nb = 0;
  logic [31:0] m_word = 32'h0;
  logic [7:0]  m_addr = 8'h0;
  logic [8:0]  m_words = 9'h0;
  bit          m_ovf = 1'b0;
  logic [7:0]  m_cs = 8'h0;
  logic [31:0] m_ram [256];
  logic [31:0] d_ram [256];
  int          done_cnt = 0;
  int          strobe_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit e_ready;
      bit e_busy;
      e_ready = act && (cyc >= rdy_from);
      e_busy  = act || (cyc == done_at);
      chk("rx_ready", o_rx_ready, e_ready);
      chk("write_enable", o_ram_write_enable, act);
      chk("busy", o_busy, e_busy);
      chk("write_next", o_ram_write_data_next, cyc == strobe_at);
      chk("done", o_done, cyc == done_at);
      chk("address", o_ram_address, m_addr);
      chk("words_loaded", o_words_loaded, m_words);
      chk("overflow", o_overflow, m_ovf);
      if (cyc == strobe_at) chk("write_data", o_ram_write_data, m_word);
`ifdef LOADER_CHECKSUM_EN
      if (cyc == done_at) chk("checksum", o_checksum, m_cs);
`endif
      // the RAM behind the port stores on every strobe
      if (o_ram_write_data_next) begin
        d_ram[o_ram_address] = o_ram_write_data;
        strobe_cnt++;
      end
      if (o_done) done_cnt++;

      if (!i_reset) begin
        act = 1'b0; rdy_from = 0; strobe_at = -1; decide_at = -1; done_at = -1;
        m_nb = 0; m_word = '0; m_addr = '0; m_words = '0; m_ovf = 1'b0; m_cs = '0;
      end else begin
        if (cyc == strobe_at) begin
          m_ram[m_addr] = m_word;
          m_words = m_words + 9'd1;
        end
        if (cyc == decide_at) begin
          if (m_word == 32'hFFFF_FFFF) begin
            act = 1'b0; done_at = cyc + 1;
          end else if (m_addr == 8'd255) begin
            m_ovf = 1'b1; act = 1'b0; done_at = cyc + 1;
          end else begin
            m_addr = m_addr + 8'd1;
          end
        end
        if (i_start && !e_busy) begin
          act = 1'b1; rdy_from = cyc + 1; m_addr = '0; m_words = '0; m_ovf = 1'b0;
          m_cs = '0; m_nb = 0;
          for (int k = 0; k < 256; k++) begin
            m_ram[k] = 'x;
            d_ram[k] = 'x;
          end
        end else if (e_ready && i_rx_valid) begin
          m_word = {m_word[23:0], i_rx_data};
          m_cs   = m_cs ^ i_rx_data;
          m_nb++;
          if (m_nb == 4) begin
            m_nb = 0;
            strobe_at = cyc + 1;
            decide_at = cyc + 1 + WW;
            rdy_from  = cyc + 2 + WW;
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers (drive at posedge + 1) ----------------
  int gap_max = 0;
  bit toggle_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(gap_max, 0)) begin
      i_rx_valid = 1'b0;
      i_rx_data  = 8'($urandom);
      tick();
    end
    i_rx_data = b;
    n = 0;
    forever begin
      if (toggle_mode) i_rx_valid = ~i_rx_valid;
      else             i_rx_valid = 1'b1;
      @(negedge clk);
      if (i_rx_valid && o_rx_ready) break;
      @(posedge clk);
      #1;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL byte_timeout: got no handshake expected one within 100 cycles");
        i_rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_done) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL done_timeout: got no o_done expected one within 200 cycles");
        break;
      end
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + randomized sequences ----------------
  initial begin
    int n;
    int d0;
    int s0;
    logic [31:0] w;
    logic [31:0] last_w;

    tick();
    mon_en = 1'b1;
    tick();
    @(negedge clk);
    chk("reset busy", o_busy, 0);
    chk("reset write_data", o_ram_write_data, 0);
    chk("reset words", o_words_loaded, 0);
    tick();
    i_reset = 1'b1;
    tick();

    // 1: single word, then terminate
    d0 = done_cnt; s0 = strobe_cnt;
    pulse_start();
    send_word(32'hAABBCC55);
    n = 0;
    forever begin
      @(negedge clk);
      if (o_rx_ready || n > 50) break;
      n++;
    end
    chk("t1 ready_low_cycles", n, 7);
    chk("t1 address", o_ram_address, 1);
    tick();
    chk("t1 strobes", strobe_cnt - s0, 1);
    chk("t1 ram0", d_ram[0], 32'hAABBCC55);
    chk("t1 model ram0", m_ram[0], 32'hAABBCC55);
    send_word(32'hFFFF_FFFF);
    wait_done();

    // 2 and 3: three words; second pass with toggling valid and a start during WAIT
    for (int pass = 0; pass < 2; pass++) begin
      toggle_mode = (pass == 1);
      d0 = done_cnt;
      pulse_start();
      send_word(32'h11223344);
      if (pass == 1) begin
        tick(); tick();
        pulse_start();
      end
      send_word(32'h89ABCDEF);
      send_word(32'hFFFF_FFFF);
      wait_done();
      chk("t2 ram0", d_ram[0], 32'h11223344);
      chk("t2 ram1", d_ram[1], 32'h89ABCDEF);
      chk("t2 ram2", d_ram[2], 32'hFFFF_FFFF);
      chk("t2 words", o_words_loaded, 3);
      chk("t2 overflow", o_overflow, 0);
      chk("t2 done pulses", done_cnt - d0, 1);
    end
    toggle_mode = 1'b0;

    // 4: overflow after 256 non-terminating words
    gap_max = 1;
    d0 = done_cnt;
    last_w = '0;
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      send_word(w);
      last_w = w;
    end
    wait_done();
    repeat (3) tick();
    chk("t4 overflow", o_overflow, 1);
    chk("t4 address", o_ram_address, 255);
    chk("t4 words", o_words_loaded, 256);
    chk("t4 ram255", d_ram[255], last_w);
    chk("t4 model ram255", m_ram[255], last_w);
    chk("t4 done pulses", done_cnt - d0, 1);

    // 5: reset mid-word, then a fresh session
    gap_max = 0;
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    i_reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t5 reset write_data", o_ram_write_data, 0);
    chk("t5 reset enable", o_ram_write_enable, 0);
    tick();
    i_reset = 1'b1;
    s0 = strobe_cnt;
    tick();
    pulse_start();
    send_word(32'h00AA00BB);
    send_word(32'hFFFF_FFFF);
    wait_done();
    chk("t5 ram0", d_ram[0], 32'h00AA00BB);
    chk("t5 strobes", strobe_cnt - s0, 2);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum of 01 02 04 08 FF FF FF FF
    pulse_start();
    send_word(32'h01020408);
    send_word(32'hFFFF_FFFF);
    wait_done();
    chk("t6 checksum", o_checksum, 8'h0F);
    chk("t6 model checksum", m_cs, 8'h0F);
`endif

    // randomized sessions
    for (int s = 0; s < 5; s++) begin
      gap_max = s % 3;
      pulse_start();
      repeat ($urandom_range(5, 1)) begin
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h1;
        send_word(w);
      end
      send_word(32'hFFFF_FFFF);
      wait_done();
      for (int k = 0; k < 8; k++) chk("rand ram image", d_ram[k], m_ram[k]);
    end

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
